// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver states and data-width limits.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam logic [3:0] MIN_DATA_BITS = 4'd5;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP1,
        RX_STOP2
    } rx_state_t;

    // Limit a requested data width to [MIN_DATA_BITS, max_bits].
    function automatic logic [3:0] clamp_data_bits(input logic [3:0] req, input logic [3:0] max_bits);
        logic [3:0] r;
        r = req;
        if (req < MIN_DATA_BITS) begin
            r = MIN_DATA_BITS;
        end else if (req > max_bits) begin
            r = max_bits;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_phy_if.sv
// Valid/ready frame channel from the UART receiver holding register to its consumer.
interface uart_rx_phy_if #(
    parameter int unsigned MAX_DATA_BITS = 9
);
    logic                     out_valid;
    logic                     out_ready;
    logic [MAX_DATA_BITS-1:0] out_data;
    logic                     out_parity_err;
    logic                     out_frame_err;
    logic                     out_break;

    modport master (
        output out_valid, out_data, out_parity_err, out_frame_err, out_break,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_parity_err, out_frame_err, out_break,
        output out_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every div+1 clocks while enabled.
module uart_baud_tick #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);
    logic [DIV_WIDTH-1:0] cnt;

    // Down-counter that reloads after reaching zero and is held at reload when disabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (!en || cnt == '0) begin
            cnt <= div;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = en && (cnt == '0);
endmodule

// File: rtl/uart_rx_phy.sv
// Oversampling UART receiver with majority voting, error detection and a one-entry output register.
module uart_rx_phy
    import uart_pkg::*;
#(
    parameter int unsigned DIV_WIDTH     = 16,
    parameter int unsigned MAX_DATA_BITS = 9,
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 cfg_en,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [3:0]           cfg_data_bits,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    uart_rx_phy_if.master        out_if,
    output logic                 overrun,
    output logic                 busy
);
    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] S_LO   = CNT_W'(OVERSAMPLE/2 - 1);
    localparam logic [CNT_W-1:0] S_MID  = CNT_W'(OVERSAMPLE/2);
    localparam logic [CNT_W-1:0] S_HI   = CNT_W'(OVERSAMPLE/2 + 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       MAX_BITS = 4'(MAX_DATA_BITS);

    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     rxs, tick, bit_val;
    rx_state_t                state_q, state_d;
    logic                     armed_q, armed_d;
    logic [CNT_W-1:0]         samp_q, samp_d;
    logic [1:0]               vote_q, vote_d;
    logic [3:0]               idx_q, idx_d, nbits_q, nbits_d;
    logic [MAX_DATA_BITS-1:0] data_q, data_d;
    logic                     par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
    logic                     par_bit_q, par_bit_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                     s1zero_q, s1zero_d;
    logic                     complete, cmp_break;

    // Bring the asynchronous line into the clock domain; idles high out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
        .clock (clock),
        .reset (reset),
        .en    (cfg_en),
        .div   (cfg_div),
        .tick  (tick)
    );

    assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs) | (vote_q[1] & rxs);
    assign busy    = (state_q != RX_IDLE);

    // Receiver state and per-frame datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RX_IDLE;
            armed_q   <= 1'b0;
            samp_q    <= '0;
            vote_q    <= '0;
            idx_q     <= '0;
            nbits_q   <= MIN_DATA_BITS;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            s1zero_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            samp_q    <= samp_d;
            vote_q    <= vote_d;
            idx_q     <= idx_d;
            nbits_q   <= nbits_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            stop2_q   <= stop2_d;
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            s1zero_q  <= s1zero_d;
        end
    end

    // Next-state: start detection, sample voting, bit decisions and frame completion.
    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        samp_d    = samp_q;
        vote_d    = vote_q;
        idx_d     = idx_q;
        nbits_d   = nbits_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        stop2_d   = stop2_q;
        par_bit_d = par_bit_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        s1zero_d  = s1zero_q;
        complete  = 1'b0;

        if (!cfg_en) begin
            state_d = RX_IDLE;
            armed_d = 1'b0;
        end else if (tick) begin
            if (state_q == RX_IDLE) begin
                if (rxs) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d   = RX_START;
                    samp_d    = '0;
                    idx_d     = '0;
                    data_d    = '0;
                    par_bit_d = 1'b0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                    s1zero_d  = 1'b0;
                    nbits_d   = clamp_data_bits(cfg_data_bits, MAX_BITS);
                    par_en_d  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
                    par_odd_d = (cfg_parity == PAR_ODD);
                    stop2_d   = cfg_stop2;
                end
            end else begin
                samp_d = (samp_q == S_LAST) ? '0 : samp_q + 1'b1;
                if (samp_q == S_LO)  vote_d[0] = rxs;
                if (samp_q == S_MID) vote_d[1] = rxs;

                if (samp_q == S_HI) begin
                    case (state_q)
                        RX_START:  if (bit_val) state_d = RX_IDLE;
                        RX_DATA:   data_d[idx_q] = bit_val;
                        RX_PARITY: begin
                            par_bit_d = bit_val;
                            if (bit_val != ((^data_q) ^ par_odd_q)) perr_d = 1'b1;
                        end
                        RX_STOP1: begin
                            s1zero_d = !bit_val;
                            if (!bit_val) ferr_d = 1'b1;
                            if (!stop2_q) complete = 1'b1;
                        end
                        RX_STOP2: begin
                            if (!bit_val) ferr_d = 1'b1;
                            complete = 1'b1;
                        end
                        default: ;
                    endcase
                end

                if (samp_q == S_LAST) begin
                    case (state_q)
                        RX_START:  state_d = RX_DATA;
                        RX_DATA: begin
                            if (idx_q == nbits_q - 4'd1) begin
                                state_d = par_en_q ? RX_PARITY : RX_STOP1;
                            end else begin
                                idx_d = idx_q + 4'd1;
                            end
                        end
                        RX_PARITY: state_d = RX_STOP1;
                        RX_STOP1:  state_d = RX_STOP2;
                        default: ;
                    endcase
                end

                // Completion lands mid-stop-bit; a zero stop bit disarms until the line returns high.
                if (complete) begin
                    state_d = RX_IDLE;
                    if (ferr_d) armed_d = 1'b0;
                end
            end
        end
    end

    assign cmp_break = (data_q == '0) && !par_bit_q && s1zero_d;

    // One-entry holding register; a completion while full and not being drained is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_if.out_valid      <= 1'b0;
            out_if.out_data       <= '0;
            out_if.out_parity_err <= 1'b0;
            out_if.out_frame_err  <= 1'b0;
            out_if.out_break      <= 1'b0;
            overrun               <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                if (!out_if.out_valid || out_if.out_ready) begin
                    out_if.out_valid      <= 1'b1;
                    out_if.out_data       <= data_q;
                    out_if.out_parity_err <= perr_q;
                    out_if.out_frame_err  <= ferr_d;
                    out_if.out_break      <= cmp_break;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_if.out_valid && out_if.out_ready) begin
                out_if.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_phy.sv
// Directed scoreboard bench for uart_rx_phy at 16 clocks per bit.
module tb_uart_rx_phy;
    localparam int unsigned BIT_CLKS = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx;
    logic        cfg_en;
    logic [15:0] cfg_div;
    logic [3:0]  cfg_data_bits;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        overrun;
    logic        busy;

    uart_rx_phy_if #(.MAX_DATA_BITS(9)) dut_if ();

    uart_rx_phy #(
        .DIV_WIDTH     (16),
        .MAX_DATA_BITS (9),
        .OVERSAMPLE    (16),
        .SYNC_STAGES   (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rx            (rx),
        .cfg_en        (cfg_en),
        .cfg_div       (cfg_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .out_if        (dut_if),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // Frame record: {data[8:0], parity_err, frame_err, break}
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    int obs_rd = 0;
    int n_checks = 0;
    int n_fail = 0;
    int ov_cycles = 0;
    int busy_cycles = 0;
    int ov0;
    int b0;

    // Record every accepted frame and count overrun/busy cycles.
    always @(negedge clock) begin
        if (!reset && dut_if.out_valid && dut_if.out_ready)
            obs_q.push_back({dut_if.out_data, dut_if.out_parity_err, dut_if.out_frame_err, dut_if.out_break});
        if (overrun) ov_cycles++;
        if (busy) busy_cycles++;
    end

    function automatic logic [11:0] mk(input logic [8:0] d, input logic pe, input logic fe, input logic br);
        return {d, pe, fe, br};
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) cyc();
    endtask

    // Drives start, data LSB first, optional parity, stop bit(s); leaves rx at the last bit.
    task automatic send_uart(input logic [8:0] d, input int nbits, input bit has_par, input logic par_bit,
                             input logic s1, input bit has_s2, input logic s2);
        hold_bit(1'b0);
        for (int i = 0; i < nbits; i++) hold_bit(d[i]);
        if (has_par) hold_bit(par_bit);
        hold_bit(s1);
        if (has_s2) hold_bit(s2);
    endtask

    task automatic check_frames(input string tag);
        int guard;
        guard = 0;
        while ((obs_q.size() - obs_rd) < exp_q.size() && guard < 400) begin
            cyc();
            guard++;
        end
        repeat (20) cyc();
        check({tag, "_count"}, obs_q.size() - obs_rd, exp_q.size());
        foreach (exp_q[i]) begin
            if (obs_rd < obs_q.size()) begin
                check(tag, obs_q[obs_rd], exp_q[i]);
                obs_rd++;
            end
        end
        obs_rd = obs_q.size();
        exp_q.delete();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        cfg_en = 1'b1;
        cfg_div = '0;
        cfg_data_bits = 4'd8;
        cfg_parity = 2'd1;
        cfg_stop2 = 1'b0;
        dut_if.out_ready = 1'b1;
        repeat (3) cyc();
        check("rst_valid", dut_if.out_valid, 0);
        check("rst_data", dut_if.out_data, 0);
        check("rst_perr", dut_if.out_parity_err, 0);
        check("rst_ferr", dut_if.out_frame_err, 0);
        check("rst_break", dut_if.out_break, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (20) cyc();

        // 8 data bits, even parity, correct parity bit
        exp_q.push_back(mk(9'h0A5, 1'b0, 1'b0, 1'b0));
        send_uart(9'h0A5, 8, 1, 1'b0, 1'b1, 0, 1'b1);
        rx = 1'b1;
        repeat (BIT_CLKS) cyc();
        check_frames("even_a5");
        check("even_overrun", ov_cycles, 0);

        // odd parity with wrong parity bit
        cfg_parity = 2'd2;
        exp_q.push_back(mk(9'h03C, 1'b1, 1'b0, 1'b0));
        send_uart(9'h03C, 8, 1, 1'b0, 1'b1, 0, 1'b1);
        rx = 1'b1;
        repeat (BIT_CLKS) cyc();
        check_frames("odd_3c");

        // 7 bits, no parity, two stop bits with second stop low; line stays low afterwards
        cfg_data_bits = 4'd7;
        cfg_parity = 2'd0;
        cfg_stop2 = 1'b1;
        exp_q.push_back(mk(9'h055, 1'b0, 1'b1, 1'b0));
        send_uart(9'h055, 7, 0, 1'b0, 1'b1, 1, 1'b0);
        repeat (3 * BIT_CLKS) cyc();
        check("stop2_noarm_busy", busy, 0);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) cyc();
        check_frames("stop2_55");

        // break: 12 bit periods low
        cfg_data_bits = 4'd8;
        cfg_parity = 2'd1;
        cfg_stop2 = 1'b0;
        exp_q.push_back(mk(9'h000, 1'b0, 1'b1, 1'b1));
        rx = 1'b0;
        repeat (12 * BIT_CLKS) cyc();
        check("break_idle_busy", busy, 0);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) cyc();
        check_frames("break");

        // overrun: consumer stalled, second frame dropped
        dut_if.out_ready = 1'b0;
        ov0 = ov_cycles;
        send_uart(9'h011, 8, 1, 1'b0, 1'b1, 0, 1'b1);
        rx = 1'b1;
        repeat (BIT_CLKS) cyc();
        send_uart(9'h022, 8, 1, 1'b0, 1'b1, 0, 1'b1);
        rx = 1'b1;
        repeat (BIT_CLKS) cyc();
        check("ovr_valid", dut_if.out_valid, 1);
        check("ovr_hold_data", dut_if.out_data, 9'h011);
        check("ovr_pulse_cycles", ov_cycles - ov0, 1);
        check_frames("ovr_stalled");
        dut_if.out_ready = 1'b1;
        exp_q.push_back(mk(9'h011, 1'b0, 1'b0, 1'b0));
        check_frames("ovr_drain");
        check("ovr_drained_valid", dut_if.out_valid, 0);

        // 3-clock glitch
        b0 = busy_cycles;
        rx = 1'b0;
        repeat (3) cyc();
        rx = 1'b1;
        repeat (40) cyc();
        check("glitch_busy_seen", (busy_cycles - b0) > 0, 1);
        check("glitch_busy_end", busy, 0);
        check_frames("glitch");

        // reset in the middle of DATA drops both the held and the partial frame
        dut_if.out_ready = 1'b0;
        send_uart(9'h077, 8, 1, 1'b0, 1'b1, 0, 1'b1);
        rx = 1'b1;
        repeat (BIT_CLKS) cyc();
        check("pre_rst_valid", dut_if.out_valid, 1);
        hold_bit(1'b0);
        hold_bit(1'b1);
        hold_bit(1'b1);
        hold_bit(1'b1);
        check("mid_data_busy", busy, 1);
        reset = 1'b1;
        cyc();
        check("rst_mid_busy", busy, 0);
        check("rst_mid_valid", dut_if.out_valid, 0);
        reset = 1'b0;
        rx = 1'b1;
        dut_if.out_ready = 1'b1;
        repeat (40) cyc();
        check_frames("rst_drop");

        exp_q.push_back(mk(9'h05A, 1'b0, 1'b0, 1'b0));
        send_uart(9'h05A, 8, 1, 1'b0, 1'b1, 0, 1'b1);
        rx = 1'b1;
        repeat (BIT_CLKS) cyc();
        check_frames("clean_5a");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
